// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_e;
  localparam int MEM_LAT_MAX = 4;
  localparam int CNT_W = $clog2(MEM_LAT_MAX);
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker, favours the port that did not own the last transaction
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  input  logic       en,
  output logic [1:0] gnt
);
  always_comb begin
    gnt[0] = en && req[0] && (!req[1] || last == OWN_DBG);
    gnt[1] = en && req[1] && (!req[0] || last == OWN_CPU);
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU and the debug/loader port
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              misalign
);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  owner_e            last_q, last_d, sel_own;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d, dbg_rvalid_q, dbg_rvalid_d;
  logic              misalign_q, misalign_d;
  logic [1:0]        gnt;
  logic              acc, cap, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_arb (
    .req ({dbg_req, cpu_req}),
    .last(last_q),
    .en  (state_q == IDLE),
    .gnt (gnt)
  );

  assign cpu_gnt    = gnt[0];
  assign dbg_gnt    = gnt[1];
  assign acc        = |gnt;
  assign cap        = state_q == WAIT && cnt_q == '0;
  assign busy       = state_q != IDLE;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign misalign   = misalign_q;

  always_comb begin
    sel_own      = gnt[1] ? OWN_DBG : OWN_CPU;
    sel_we       = gnt[1] ? dbg_we : cpu_we;
    sel_addr     = gnt[1] ? dbg_addr : cpu_addr;
    sel_wdata    = gnt[1] ? dbg_wdata : cpu_wdata;
    mem_en_d     = acc;
    mem_we_d     = acc && sel_we;
    mem_addr_d   = acc ? sel_addr[ADDR_W-1:2] : mem_addr_q;
    mem_wdata_d  = acc ? sel_wdata : mem_wdata_q;
    misalign_d   = misalign_q || (acc && sel_addr[1:0] != 2'b00);
    cpu_rvalid_d = cap && last_q == OWN_CPU;
    dbg_rvalid_d = cap && last_q == OWN_DBG;
    cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
    dbg_rdata_d  = dbg_rvalid_d ? mem_rdata : dbg_rdata_q;
    state_d      = state_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = acc ? ISSUE : IDLE;
        last_d  = acc ? sel_own : last_q;
      end
      ISSUE: begin
        state_d = mem_we_q ? IDLE : WAIT;
        cnt_d   = LAT_M1;
      end
      WAIT: begin
        state_d = cap ? RESP : WAIT;
        cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= IDLE;
      last_q       <= OWN_DBG;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      misalign_q   <= misalign_d;
    end
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the CPU's single-port data memory between two requesters: the CPU multi-cycle controller (load/store phase) and a debug/loader port used to preload or inspect data memory. Each request is accepted with a handshake, issued to memory in a registered cycle, and, for reads, answered with a one-cycle valid pulse after a parameterised read latency. Sits between the `cu`/`mem_write` path and the debug front end.

## Interface
- `ADDR_W`, 32, byte-address width of both requester ports
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, memory read latency in cycles after the sampling edge (legal range 1..4)

Ports:
- `clk` in 1: single clock; all state changes on rising edge
- `rst_n` in 1: reset; **synchronous, active-high** (asserted = 1)
- `cpu_req` in 1: CPU request; held until accepted
- `cpu_we` in 1: 1 = write, 0 = read
- `cpu_addr` in ADDR_W: byte address
- `cpu_wdata` in DATA_W: write data
- `cpu_gnt` out 1: request accepted this cycle (`cpu_req && cpu_gnt`)
- `cpu_rvalid` out 1: one-cycle pulse; `cpu_rdata` valid
- `cpu_rdata` out DATA_W: last read data for CPU; held until next CPU read completes
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same as CPU port
- `mem_en` out 1: memory access strobe
- `mem_we` out 1: memory write enable (only meaningful with `mem_en`)
- `mem_addr` out ADDR_W-2: word address = accepted addr[ADDR_W-1:2]
- `mem_wdata` out DATA_W: write data
- `mem_rdata` in DATA_W: memory read data
- `busy` out 1: high in any state other than IDLE
- `misalign` out 1: sticky; set when an accepted addr has addr[1:0] != 0

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grants are combinational. At most one grant is high. If only one port requests, it is granted. If both request, the port that did not own the last transaction is granted (round-robin). The last-owner register resets to DBG, so the CPU wins the first tie.
- Acceptance (`req && gnt`) latches owner, we, addr, and wdata, then goes to ISSUE. Misaligned accesses are still issued with the low 2 bits dropped, and `misalign` is set.
- ISSUE: `mem_en=1`, with `mem_we`/`mem_addr`/`mem_wdata` driven from registers. A write goes to IDLE. A read loads the latency counter with MEM_LAT-1 and goes to WAIT.
- WAIT: the counter decrements each cycle. At 0, `mem_rdata` is captured into the owner's rdata register and the FSM goes to RESP.
- RESP: the owner's `rvalid`=1 for exactly one cycle, then the FSM goes to IDLE.
- Grants are 0 in ISSUE, WAIT, and RESP. Requests arriving then wait; no request is dropped or reordered.
- The non-owner's rdata register is never modified.
- Reset values: all `gnt`/`rvalid`/`mem_en`/`mem_we`/`busy`/`misalign` = 0; `mem_addr`/`mem_wdata`/`*_rdata` = 0; state = IDLE; last owner = DBG.
- Reset mid-transaction aborts it. No `rvalid` is produced for it, and `mem_en` is 0 in the cycle after the reset edge.

## Timing
- Cycle 0: accept in IDLE.
- Cycle 1: ISSUE (memory samples at the end of cycle 1).
- Write: IDLE at cycle 2. Occupancy is 2 cycles per write.
- Read: `mem_rdata` is valid in cycle 1+MEM_LAT and captured at its end. `rvalid` is high in cycle 2+MEM_LAT. IDLE at cycle 3+MEM_LAT. With MEM_LAT=1: `rvalid` in cycle 3, next grant possible in cycle 4.
- `mem_*` outputs are registered. `gnt` is combinational from the `req` inputs in IDLE only.

## Structure
- Shared package `dmem_pkg`:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - owner enum (OWN_CPU/OWN_DBG)
  - `MEM_LAT` bound constant
- Sub-module `rr_arb2`: two-input round-robin picker.
  - Inputs: `req[1:0]`, `last`, `en`.
  - Output: one-hot `gnt[1:0]`.
  - Purely combinational; the last-owner register stays in the parent.

## Test plan
- Reset, then CPU write addr 0x10, data 0xDEADBEEF: `cpu_gnt` in cycle 0; `mem_en=1`, `mem_we=1`, `mem_addr=0x4`, `mem_wdata=0xDEADBEEF` in cycle 1; `busy` low in cycle 2.
- DBG read addr 0x10 with a memory model returning 0xDEADBEEF, MEM_LAT=1: `dbg_rvalid` single pulse in cycle 3 with `dbg_rdata=0xDEADBEEF`; `cpu_rdata` stays 0.
- Both ports request continuously from reset: grants alternate CPU, DBG, CPU, DBG, and no grant occurs while `busy`=1.
- MEM_LAT=3, CPU read: `cpu_rvalid` in cycle 5, exactly one cycle wide; `dbg_req` raised in cycle 2 is granted in cycle 6.
- CPU read to 0x13: `mem_addr=0x4`, `misalign`=1 and stays 1 through later aligned accesses until reset.
- Reset asserted in WAIT of a DBG read: no `dbg_rvalid`; all outputs 0 the next cycle; next tie goes to CPU.
